line_read_scheduler: RTL and testbench
======================================

// Module: line_read_scheduler
// PURPOSE
//  Read-side sequencer for the HDMI input FIFO (data_in_fifo, read port) that feeds the bilinear scaler.
//  Issues line bursts of exactly H_PIX reads when the FIFO holds a full line, and inserts a fixed line gap.
//  Generates frame/line framing aligned to FIFO rdata (1-cycle read latency) and flags underruns.
//  Replaces ad-hoc read control; single-clock, all inputs pre-synchronised to sys_clk_96M.
// PARAMETERS
//  H_PIX       640   reads per line (1..2047)
//  V_PIX       480   lines per frame (1..2047)
//  H_GAP       16    idle cycles between line bursts (0 = back-to-back line checks)
//  PREFILL_TH  3000  FIFO level required before a frame starts
//  TIMEOUT     65535 watchdog cycles in WAIT_LINE (LINE_TIMEOUT_EN only)
// PORTS
//  sys_clk_96M     in   1   clock
//  sys_rst_n       in   1   reset, asynchronous, active-low
//  cfg_done_i      in   1   ADV7611 configuration complete (level)
//  enable_i        in   1   scheduler enable, sampled at frame boundaries
//  rd_datacount_i  in   16  FIFO read-side occupancy
//  rd_en_o         out  1   FIFO read strobe
//  hsync_o         out  1   line-valid, rd_en_o delayed 1 cycle (qualifies rdata)
//  vsync_o         out  1   frame-valid
//  line_cnt_o      out  11  completed lines in current frame
//  frame_done_o    out  1   1-cycle pulse at end of frame
//  underrun_o      out  1   sticky: read issued while rd_datacount_i==0
//  timeout_o       out  1   1-cycle pulse on watchdog abort (0 without LINE_TIMEOUT_EN)
//  state_o         out  3   current state encoding (debug)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Every output registered.
//  States: IDLE=0 PREFILL=1 WAIT_LINE=2 BURST=3 GAP=4 FRAME_END=5.
//  IDLE: cfg_done_i && enable_i -> PREFILL.
//  PREFILL: rd_datacount_i >= PREFILL_TH -> WAIT_LINE; vsync_o=1 from the next cycle.
//  WAIT_LINE: rd_datacount_i >= H_PIX -> BURST; rd_en_o high the next cycle.
//  BURST: rd_en_o high exactly H_PIX consecutive cycles; h_cnt 0..H_PIX-1.
//    On h_cnt==H_PIX-1: line_cnt_o+1, rd_en_o low next cycle.
//    Then GAP if H_GAP>0, else the post-gap decision is taken directly.
//  GAP: H_GAP idle cycles, then:
//    line_cnt_o==V_PIX -> FRAME_END;
//    else -> WAIT_LINE.
//  FRAME_END (1 cycle): vsync_o=0, frame_done_o=1, line_cnt_o cleared.
//    Then -> PREFILL if enable_i && cfg_done_i, else IDLE.
//  hsync_o = rd_en_o registered once; the last hsync_o cycle precedes vsync_o fall by >=1 cycle.
//  enable_i deassert mid-frame: current frame completes normally; checked only in FRAME_END.
//  cfg_done_i deassert in any state: next cycle -> IDLE.
//    rd_en_o, hsync_o, vsync_o, line_cnt_o = 0; no frame_done_o pulse.
//  Underrun: rd_en_o && rd_datacount_i==0 sets underrun_o; cleared only by reset. Reads continue.
//  Count compares are unsigned 16-bit; H_PIX/PREFILL_TH are zero-extended.
//  line_cnt_o never exceeds V_PIX.
// CONFIGURATION
//  LINE_TIMEOUT_EN defined:
//    16-bit watchdog counts cycles spent in WAIT_LINE; it resets on entering WAIT_LINE.
//    Reaching TIMEOUT -> timeout_o pulse, vsync_o=0, line_cnt_o=0, -> PREFILL. No frame_done_o.
//  LINE_TIMEOUT_EN undefined: no watchdog logic; WAIT_LINE waits indefinitely; timeout_o tied 0.
// TESTING (H_PIX=8 V_PIX=4 H_GAP=2 PREFILL_TH=20 TIMEOUT=50)
//  1. cfg_done=1, enable=1, count held 40 -> vsync_o rises; 4 bursts of exactly 8 rd_en_o cycles,
//     2-cycle gaps, hsync_o = rd_en_o delayed 1; frame_done_o single pulse, line_cnt_o 1,2,3,4 then 0.
//  2. count 19 for 100 cycles, then 20 -> no rd_en_o/vsync_o before 20; first rd_en_o 2 cycles after
//     count reaches 20 (one cycle to enter WAIT_LINE, one to enter BURST).
//  3. count 7 in WAIT_LINE -> rd_en_o stays 0; count->8 -> burst of 8 starts the next cycle.
//  4. Drop cfg_done mid-burst at h_cnt=3 -> next cycle rd_en_o=0, vsync_o=0, state_o=0,
//     no frame_done_o; raise again -> restarts at PREFILL.
//  5. Force count 0 during a burst -> underrun_o=1 and stays 1 after two more frames;
//     drop enable in line 2 -> frame finishes, then IDLE.
//  6. LINE_TIMEOUT_EN, count stuck 5 in WAIT_LINE -> timeout_o pulse at cycle 50, vsync_o=0, PREFILL;
//     build without macro -> timeout_o always 0, state stays WAIT_LINE.

Source files
------------

// File: rtl/line_read_scheduler.sv
// Read-side sequencer for the HDMI input FIFO: issues whole-line read bursts with a fixed gap and frame framing.
// Optional watchdog on WAIT_LINE is enabled by defining LINE_TIMEOUT_EN.
module line_read_scheduler #(
  parameter int unsigned H_PIX      = 640,
  parameter int unsigned V_PIX      = 480,
  parameter int unsigned H_GAP      = 16,
  parameter int unsigned PREFILL_TH = 3000,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic        sys_clk_96M,
  input  logic        sys_rst_n,
  input  logic        cfg_done_i,
  input  logic        enable_i,
  input  logic [15:0] rd_datacount_i,
  output logic        rd_en_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [10:0] line_cnt_o,
  output logic        frame_done_o,
  output logic        underrun_o,
  output logic        timeout_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PREFILL   = 3'd1,
    WAIT_LINE = 3'd2,
    BURST     = 3'd3,
    GAP       = 3'd4,
    FRAME_END = 3'd5
  } state_t;

  localparam logic [15:0] H_PIX_LVL   = 16'(H_PIX);
  localparam logic [15:0] PREFILL_LVL = 16'(PREFILL_TH);
  localparam logic [10:0] H_LAST      = 11'(H_PIX - 1);
  localparam logic [10:0] V_LINES     = 11'(V_PIX);
  localparam logic [15:0] GAP_LAST    = 16'((H_GAP > 0) ? H_GAP - 1 : 0);
  localparam bit          HAS_GAP     = (H_GAP > 0);

  state_t      state_q, state_n;
  logic [10:0] h_cnt_q, h_cnt_n;
  logic [15:0] g_cnt_q, g_cnt_n;
  logic [10:0] line_cnt_q, line_cnt_n;
  logic        rd_en_q, rd_en_n;
  logic        hsync_q, hsync_n;
  logic        vsync_q, vsync_n;
  logic        frame_done_q, frame_done_n;
  logic        underrun_q, underrun_n;
  logic        timeout_q, timeout_n;
  logic [10:0] line_inc;

`ifdef LINE_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wd_cnt_q, wd_cnt_n;
`endif

  assign line_inc = line_cnt_q + 11'd1;

  always_comb begin
    // NOTE: every next-value is defaulted first so no branch can leave one unassigned and infer a latch.
    state_n      = state_q;
    h_cnt_n      = h_cnt_q;
    g_cnt_n      = g_cnt_q;
    line_cnt_n   = line_cnt_q;
    rd_en_n      = 1'b0;
    hsync_n      = rd_en_q;
    vsync_n      = vsync_q;
    frame_done_n = 1'b0;
    timeout_n    = 1'b0;
    underrun_n   = underrun_q | (rd_en_q & (rd_datacount_i == 16'd0));
`ifdef LINE_TIMEOUT_EN
    wd_cnt_n     = wd_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        vsync_n    = 1'b0;
        line_cnt_n = '0;
        if (enable_i) state_n = PREFILL;
      end

      PREFILL: begin
        if (rd_datacount_i >= PREFILL_LVL) begin
          state_n = WAIT_LINE;
          vsync_n = 1'b1;
`ifdef LINE_TIMEOUT_EN
          wd_cnt_n = '0;
`endif
        end
      end

      WAIT_LINE: begin
        if (rd_datacount_i >= H_PIX_LVL) begin
          state_n = BURST;
          rd_en_n = 1'b1;
          h_cnt_n = '0;
        end
`ifdef LINE_TIMEOUT_EN
        else if (wd_cnt_q == WD_LAST) begin
          state_n    = PREFILL;
          timeout_n  = 1'b1;
          vsync_n    = 1'b0;
          line_cnt_n = '0;
        end else begin
          wd_cnt_n = wd_cnt_q + 16'd1;
        end
`endif
      end

      BURST: begin
        if (h_cnt_q == H_LAST) begin
          line_cnt_n = line_inc;
          g_cnt_n    = '0;
          // With no gap, the final line still passes through one GAP cycle so hsync drains before vsync falls.
          if (HAS_GAP || (line_inc == V_LINES)) begin
            state_n = GAP;
          end else begin
            state_n = WAIT_LINE;
`ifdef LINE_TIMEOUT_EN
            wd_cnt_n = '0;
`endif
          end
        end else begin
          rd_en_n = 1'b1;
          h_cnt_n = h_cnt_q + 11'd1;
        end
      end

      GAP: begin
        if (g_cnt_q == GAP_LAST) begin
          if (line_cnt_q == V_LINES) begin
            state_n      = FRAME_END;
            vsync_n      = 1'b0;
            frame_done_n = 1'b1;
            line_cnt_n   = '0;
          end else begin
            state_n = WAIT_LINE;
`ifdef LINE_TIMEOUT_EN
            wd_cnt_n = '0;
`endif
          end
        end else begin
          g_cnt_n = g_cnt_q + 16'd1;
        end
      end

      FRAME_END: begin
        state_n = enable_i ? PREFILL : IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // Losing the receiver configuration abandons the frame silently from any state.
    if (!cfg_done_i) begin
      state_n      = IDLE;
      rd_en_n      = 1'b0;
      hsync_n      = 1'b0;
      vsync_n      = 1'b0;
      line_cnt_n   = '0;
      frame_done_n = 1'b0;
      timeout_n    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk_96M or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      h_cnt_q      <= '0;
      g_cnt_q      <= '0;
      line_cnt_q   <= '0;
      rd_en_q      <= 1'b0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_n;
      h_cnt_q      <= h_cnt_n;
      g_cnt_q      <= g_cnt_n;
      line_cnt_q   <= line_cnt_n;
      rd_en_q      <= rd_en_n;
      hsync_q      <= hsync_n;
      vsync_q      <= vsync_n;
      frame_done_q <= frame_done_n;
      underrun_q   <= underrun_n;
      timeout_q    <= timeout_n;
    end
  end

`ifdef LINE_TIMEOUT_EN
  always_ff @(posedge sys_clk_96M or negedge sys_rst_n) begin
    if (!sys_rst_n) wd_cnt_q <= '0;
    else            wd_cnt_q <= wd_cnt_n;
  end
`endif

  assign rd_en_o      = rd_en_q;
  assign hsync_o      = hsync_q;
  assign vsync_o      = vsync_q;
  assign line_cnt_o   = line_cnt_q;
  assign frame_done_o = frame_done_q;
  assign underrun_o   = underrun_q;
  assign timeout_o    = timeout_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_line_read_scheduler.sv
// Directed bench for line_read_scheduler with H_PIX=8 V_PIX=4 H_GAP=2 PREFILL_TH=20 TIMEOUT=50.
// Outputs are sampled on the falling edge; inputs change right after sampling.
module tb_line_read_scheduler;

  logic        clk;
  logic        rst_n;
  logic        cfg_done;
  logic        enable;
  logic [15:0] count;
  logic        rd_en;
  logic        hsync;
  logic        vsync;
  logic [10:0] line_cnt;
  logic        frame_done;
  logic        underrun;
  logic        timeout;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  line_read_scheduler #(
    .H_PIX(8), .V_PIX(4), .H_GAP(2), .PREFILL_TH(20), .TIMEOUT(50)
  ) dut (
    .sys_clk_96M   (clk),
    .sys_rst_n     (rst_n),
    .cfg_done_i    (cfg_done),
    .enable_i      (enable),
    .rd_datacount_i(count),
    .rd_en_o       (rd_en),
    .hsync_o       (hsync),
    .vsync_o       (vsync),
    .line_cnt_o    (line_cnt),
    .frame_done_o  (frame_done),
    .underrun_o    (underrun),
    .timeout_o     (timeout),
    .state_o       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Starts on the WAIT_LINE cycle of a line, ends on the cycle after the line's gap.
  task automatic expect_line(input int line, input int zero_k);
    logic [15:0] saved;
    saved = count;
    check("wait_state", 32'(state), 2);
    check("wait_rd_en", 32'(rd_en), 0);
    check("wait_hsync", 32'(hsync), 0);
    check("wait_vsync", 32'(vsync), 1);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check("burst_rd_en", 32'(rd_en), 1);
      check("burst_hsync", 32'(hsync), 32'(k != 0));
      check("burst_state", 32'(state), 3);
      check("burst_line_cnt", 32'(line_cnt), line);
      if (k == zero_k) count = 16'd0;
      else             count = saved;
    end
    tick(1);
    check("gap1_rd_en", 32'(rd_en), 0);
    check("gap1_hsync", 32'(hsync), 1);
    check("gap1_state", 32'(state), 4);
    check("gap1_line_cnt", 32'(line_cnt), line + 1);
    check("gap1_vsync", 32'(vsync), 1);
    tick(1);
    check("gap2_hsync", 32'(hsync), 0);
    check("gap2_state", 32'(state), 4);
    check("gap2_vsync", 32'(vsync), 1);
    tick(1);
  endtask

  task automatic expect_frame_end();
    check("fe_state", 32'(state), 5);
    check("fe_frame_done", 32'(frame_done), 1);
    check("fe_vsync", 32'(vsync), 0);
    check("fe_line_cnt", 32'(line_cnt), 0);
    check("fe_hsync", 32'(hsync), 0);
    check("fe_rd_en", 32'(rd_en), 0);
  endtask

  task automatic expect_frame();
    for (int l = 0; l < 4; l++) expect_line(l, -1);
    expect_frame_end();
  endtask

  initial begin
    rst_n    = 1'b0;
    cfg_done = 1'b0;
    enable   = 1'b0;
    count    = 16'd0;
    tick(2);
    check("rst_state", 32'(state), 0);
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_hsync", 32'(hsync), 0);
    check("rst_vsync", 32'(vsync), 0);
    check("rst_line_cnt", 32'(line_cnt), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_timeout", 32'(timeout), 0);

    // Full frame with a steady FIFO level.
    rst_n    = 1'b1;
    cfg_done = 1'b1;
    enable   = 1'b1;
    count    = 16'd40;
    tick(1);
    check("t1_prefill_state", 32'(state), 1);
    check("t1_prefill_vsync", 32'(vsync), 0);
    check("t1_prefill_rd_en", 32'(rd_en), 0);
    tick(1);
    expect_frame();

    // Prefill threshold boundary: 19 holds, 20 releases.
    count = 16'd19;
    tick(1);
    check("t2_pulse_single", 32'(frame_done), 0);
    check("t2_state_prefill", 32'(state), 1);
    for (int i = 0; i < 99; i++) begin
      tick(1);
      check("t2_hold_state", 32'(state), 1);
      check("t2_hold_rd_en", 32'(rd_en), 0);
      check("t2_hold_vsync", 32'(vsync), 0);
    end
    count = 16'd20;
    tick(1);
    expect_line(0, -1);

    // Line threshold boundary: 7 holds, 8 releases.
    count = 16'd7;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("t3_hold_state", 32'(state), 2);
      check("t3_hold_rd_en", 32'(rd_en), 0);
    end
    count = 16'd8;
    expect_line(1, -1);

    // Configuration loss mid-burst at h_cnt=3.
    tick(4);
    check("t4_burst_rd_en", 32'(rd_en), 1);
    check("t4_burst_state", 32'(state), 3);
    cfg_done = 1'b0;
    tick(1);
    check("t4_drop_rd_en", 32'(rd_en), 0);
    check("t4_drop_vsync", 32'(vsync), 0);
    check("t4_drop_state", 32'(state), 0);
    check("t4_drop_hsync", 32'(hsync), 0);
    check("t4_drop_line_cnt", 32'(line_cnt), 0);
    check("t4_drop_frame_done", 32'(frame_done), 0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("t4_idle_state", 32'(state), 0);
      check("t4_idle_frame_done", 32'(frame_done), 0);
    end
    cfg_done = 1'b1;
    count    = 16'd40;
    tick(1);
    check("t4_restart_state", 32'(state), 1);
    tick(1);

    // Underrun during a burst, enable dropped in line 2.
    check("t5_underrun_before", 32'(underrun), 0);
    expect_line(0, 2);
    check("t5_underrun_set", 32'(underrun), 1);
    enable = 1'b0;
    expect_line(1, -1);
    expect_line(2, -1);
    expect_line(3, -1);
    expect_frame_end();
    tick(1);
    check("t5_idle_state", 32'(state), 0);
    tick(1);
    check("t5_idle_hold", 32'(state), 0);
    enable = 1'b1;
    tick(1);
    check("t5_restart_state", 32'(state), 1);
    tick(1);
    expect_frame();
    tick(2);
    expect_frame();
    check("t5_underrun_sticky", 32'(underrun), 1);

    // Starved WAIT_LINE.
    count = 16'd20;
    tick(2);
    check("t6_wait_state", 32'(state), 2);
    count = 16'd5;
    for (int i = 1; i <= 60; i++) begin
      tick(1);
`ifdef LINE_TIMEOUT_EN
      if (i < 50) begin
        check("t6_wd_state", 32'(state), 2);
        check("t6_wd_timeout", 32'(timeout), 0);
      end else if (i == 50) begin
        check("t6_wd_fire", 32'(timeout), 1);
        check("t6_wd_state_prefill", 32'(state), 1);
        check("t6_wd_vsync", 32'(vsync), 0);
        check("t6_wd_line_cnt", 32'(line_cnt), 0);
        check("t6_wd_frame_done", 32'(frame_done), 0);
      end else begin
        check("t6_wd_after", 32'(timeout), 0);
        check("t6_wd_after_state", 32'(state), 1);
      end
`else
      check("t6_stuck_state", 32'(state), 2);
      check("t6_stuck_timeout", 32'(timeout), 0);
      check("t6_stuck_rd_en", 32'(rd_en), 0);
      check("t6_stuck_vsync", 32'(vsync), 1);
`endif
    end

    // Asynchronous reset clears everything, including the sticky underrun flag.
    rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 0);
    check("arst_underrun", 32'(underrun), 0);
    check("arst_vsync", 32'(vsync), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
